// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM encoding,
// datapath widths and the legal range of the multiplier settle latency.
package mult_arbiter_pkg;

    localparam int OP_W        = 4;
    localparam int PROD_W      = 16;
    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 7;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot response/grant vector for a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_arbiter_array_multiplier.sv
// Combinational unsigned array multiplier: one shifted partial product per
// multiplier bit, accumulated through a ripple chain of adders.
module array_multiplier
    import mult_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [2*OP_W-1:0] pp  [OP_W];
    logic [2*OP_W-1:0] acc [OP_W+1];

    assign acc[0] = '0;

    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_row
            assign pp[gi]    = b[gi] ? ({{OP_W{1'b0}}, a} << gi) : '0;
            assign acc[gi+1] = acc[gi] + pp[gi];
        end
    endgenerate

    // The 4x4 product never exceeds 8 bits; the upper byte is always zero.
    assign p = {{(PROD_W-2*OP_W){1'b0}}, acc[OP_W]};

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester arbiter around one shared multiplier (IDLE -> CALC -> RESP).
// Define MULT_ARBITER_RR_EN for round-robin grant; default is fixed priority.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [PROD_W-1:0] rsp_p,
    output logic              busy
);

    generate
        if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_lat
            $error("mult_arbiter: MUL_LAT out of range 1..7");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   a_lat;
    logic [OP_W-1:0]   b_lat;
    logic              owner;
    logic [1:0]        grant;
    logic              accept;
    logic [OP_W-1:0]   a_sel;
    logic [OP_W-1:0]   b_sel;
    logic [PROD_W-1:0] mul_p;

`ifdef MULT_ARBITER_RR_EN
    logic last_served;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (req_valid == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else begin
            grant = req_valid;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`endif

    assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign a_sel     = grant[1] ? a1 : a0;
    assign b_sel     = grant[1] ? b1 : b0;

    array_multiplier u_mul (
        .a (a_lat),
        .b (b_lat),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            owner     <= 1'b0;
            rsp_p     <= '0;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
`ifdef MULT_ARBITER_RR_EN
            last_served <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_lat <= a_sel;
                        b_lat <= b_sel;
                        owner <= grant[1];
                        cnt   <= '0;
                        state <= ST_CALC;
                        busy  <= 1'b1;
`ifdef MULT_ARBITER_RR_EN
                        last_served <= grant[1];
`endif
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 1'b1;
                    // Multiplier inputs have been stable for MUL_LAT cycles here.
                    if (cnt == CNT_LAST) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= onehot2(owner);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus random
// back-to-back traffic checked against a transaction-level reference model.
module tb_mult_arbiter;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  a0, b0, a1, b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_p;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          last_served = 1;
    logic [15:0] exp_p = 16'h0000;

    always #5 clk = ~clk;

    mult_arbiter #(.MUL_LAT(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    // Which requester the arbitration rule serves for a non-empty request mask.
    function automatic int pick(input logic [1:0] m);
        if (m == 2'b01) return 0;
        if (m == 2'b10) return 1;
`ifdef MULT_ARBITER_RR_EN
        return (last_served == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // One complete transaction: grant, settle, optional backpressure, release.
    task automatic run_txn(input logic [1:0] mask, input logic [3:0] xa0, input logic [3:0] xb0,
                           input logic [3:0] xa1, input logic [3:0] xb1, input int hold,
                           input string tag);
        int          own;
        logic [1:0]  oh;
        logic [15:0] prod;
        own  = pick(mask);
        oh   = (own == 1) ? 2'b10 : 2'b01;
        prod = (own == 1) ? 16'(xa1) * 16'(xb1) : 16'(xa0) * 16'(xb0);

        req_valid = mask; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== oh) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b required %b", tag, req_ready, oh);
        end
        @(posedge clk); #1;
        last_served = own;
        // Scramble inputs: latched operands and the FSM must ignore them now.
        req_valid = 2'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom);
        #1;
        checks++;
        if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL %s calc_entry: busy=%b req_ready=%b rsp_valid=%b required 1/00/00",
                     tag, busy, req_ready, rsp_valid);
        end
        for (int i = 1; i < ML; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00 || rsp_p !== exp_p) begin
                errors++;
                $display("FAIL %s early_rsp: rsp_valid=%b rsp_p=%0d required 00/%0d",
                         tag, rsp_valid, rsp_p, exp_p);
            end
        end
        @(posedge clk); #1;
        exp_p = prod;
        checks++;
        if (rsp_valid !== oh || rsp_p !== exp_p || rsp_p[15:8] !== 8'h00) begin
            errors++;
            $display("FAIL %s result: rsp_valid=%b rsp_p=%0d required %b/%0d",
                     tag, rsp_valid, rsp_p, oh, exp_p);
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = (i % 2 == 1) ? ~oh : 2'b00;
            req_valid = 2'($urandom);
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== oh || rsp_p !== exp_p || busy !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL %s hold%0d: rsp_valid=%b rsp_p=%0d busy=%b required %b/%0d/1",
                         tag, i, rsp_valid, rsp_p, busy, oh, exp_p);
            end
        end
        rsp_ready = oh | 2'($urandom_range(0, 3));
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_p !== exp_p) begin
            errors++;
            $display("FAIL %s release: busy=%b rsp_valid=%b rsp_p=%0d required 0/00/%0d",
                     tag, busy, rsp_valid, rsp_p, exp_p);
        end
        rsp_ready = 2'b00;
        $display("txn %s mask=%b owner=%0d p=%0d hold=%0d", tag, mask, own, exp_p, hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_p !== 16'h0000 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset: busy=%b rsp_valid=%b rsp_p=%0d req_ready=%b required 0/00/0/00",
                     busy, rsp_valid, rsp_p, req_ready);
        end
        rst_n = 1'b1;
        exp_p = 16'h0000;
        last_served = 1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_single();
        run_txn(2'b01, 4'd7, 4'd9, 4'd0, 4'd0, 0, "single");
    endtask

    task automatic test_simultaneous();
        run_txn(2'b11, 4'd5, 4'd3, 4'd15, 4'd15, 0, "simul_a");
        run_txn(2'b11, 4'd5, 4'd3, 4'd15, 4'd15, 0, "simul_b");
    endtask

    task automatic test_backpressure();
        run_txn(2'b01, 4'd11, 4'd13, 4'd2, 4'd2, 10, "backpressure");
    endtask

    task automatic test_boundary();
        run_txn(2'b01, 4'd0, 4'd15, 4'd1, 4'd1, 0, "zero_a");
        run_txn(2'b10, 4'd1, 4'd1, 4'd15, 4'd0, 0, "zero_b");
        run_txn(2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 0, "max");
    endtask

    task automatic test_non_owner();
        // Hold cycles alternate rsp_ready between 00 and the non-owner bit (01).
        run_txn(2'b10, 4'd3, 4'd3, 4'd6, 4'd7, 4, "non_owner");
    endtask

    task automatic test_dropped();
        req_valid = 2'b01; a0 = 4'd3; b0 = 4'd4;
        #2;
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_p !== exp_p) begin
                errors++;
                $display("FAIL dropped%0d: busy=%b rsp_valid=%b rsp_p=%0d required 0/00/%0d",
                         i, busy, rsp_valid, rsp_p, exp_p);
            end
        end
        $display("txn dropped request ignored");
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        req_valid = 2'b10; a1 = 4'd9; b1 = 4'd9; rsp_ready = 2'b11;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_p = 16'h0000;
        last_served = 1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_p !== 16'h0000 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: busy=%b rsp_valid=%b rsp_p=%0d required 0/00/0",
                     busy, rsp_valid, rsp_p);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < ML + 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_orphan: abandoned request still produced activity, required none");
        end
        rsp_ready = 2'b00;
        $display("txn reset mid-calc abandoned");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_boundary();
        test_non_owner();
        test_dropped();
        test_reset_mid();
        test_simultaneous();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
